// File: rtl/cnn_out_pkg.sv
// Shared defaults and FSM encoding for the classifier output collector.
package cnn_out_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARGMAX = 2'd1,
        S_SEND   = 2'd2
    } state_t;
endpackage

// File: rtl/score_cmp.sv
// Signed score comparator: a wins over b when strictly greater, or equal with a lower index.
module score_cmp #(
    parameter int DATA_W = cnn_out_pkg::DATA_W,
    parameter int IDX_W  = cnn_out_pkg::IDX_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic        [IDX_W-1:0]  idx_a,
    input  logic        [IDX_W-1:0]  idx_b,
    output logic                     a_wins
);
    assign a_wins = (a > b) || ((a == b) && (idx_a < idx_b));
endmodule

// File: rtl/cnn_score_collector.sv
// Captures one image's class scores, finds the argmax one compare per cycle,
// then streams the scores out on a valid/ready port.
module cnn_score_collector #(
    parameter int NUM_CLASSES = cnn_out_pkg::NUM_CLASSES,
    parameter int DATA_W      = cnn_out_pkg::DATA_W,
    parameter int IDX_W       = cnn_out_pkg::IDX_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          scores_valid,
    input  logic [NUM_CLASSES*DATA_W-1:0] scores_in,
    output logic [DATA_W-1:0]             ser_data,
    output logic                          ser_valid,
    input  logic                          ser_ready,
    output logic                          ser_last,
    output logic [IDX_W-1:0]              index_out,
    output logic                          index_valid,
    output logic                          busy,
    output logic                          overrun
);
    import cnn_out_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                          state, state_next;
    logic [NUM_CLASSES*DATA_W-1:0]   bank;
    logic [IDX_W-1:0]                cnt, cnt_inc, best_idx;
    logic signed [DATA_W-1:0]        best_val, cur, nxt;
    logic                            cur_wins, last_cnt, beat_done;

    // cnt walks the bank twice: as compare index k, then as beat index.
    assign cnt_inc   = cnt + 1'b1;
    assign cur       = bank[int'(cnt) * DATA_W +: DATA_W];
    assign nxt       = bank[int'(cnt_inc) * DATA_W +: DATA_W];
    assign last_cnt  = (cnt == LAST_IDX);
    assign beat_done = ser_valid && ser_ready;
    assign busy      = (state != S_IDLE);

    score_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
        .a      (cur),
        .b      (best_val),
        .idx_a  (cnt),
        .idx_b  (best_idx),
        .a_wins (cur_wins)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (scores_valid)          state_next = S_ARGMAX;
            S_ARGMAX: if (last_cnt)              state_next = S_SEND;
            S_SEND:   if (beat_done && last_cnt) state_next = S_IDLE;
            default:                             state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank        <= '0;
            cnt         <= '0;
            best_idx    <= '0;
            best_val    <= '0;
            ser_data    <= '0;
            ser_valid   <= 1'b0;
            ser_last    <= 1'b0;
            index_out   <= '0;
            index_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            index_valid <= 1'b0;
            if (scores_valid && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (scores_valid) begin
                        bank     <= scores_in;
                        best_idx <= '0;
                        best_val <= scores_in[DATA_W-1:0];
                        cnt      <= IDX_W'(1);
                    end
                end
                S_ARGMAX: begin
                    if (cur_wins) begin
                        best_idx <= cnt;
                        best_val <= cur;
                    end
                    if (last_cnt) begin
                        // Final compare result goes straight to the output.
                        index_out   <= cur_wins ? cnt : best_idx;
                        index_valid <= 1'b1;
                        ser_valid   <= 1'b1;
                        ser_data    <= bank[DATA_W-1:0];
                        ser_last    <= (NUM_CLASSES == 1);
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_SEND: begin
                    if (beat_done) begin
                        if (last_cnt) begin
                            ser_valid <= 1'b0;
                            ser_last  <= 1'b0;
                        end else begin
                            cnt      <= cnt_inc;
                            ser_data <= nxt;
                            ser_last <= (cnt_inc == LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
